// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: default sizes, Gray-code helpers
// and the write-side full compare.
package fifo_pkg;

    localparam int unsigned ADDRSIZE_DEF = 8;
    localparam int unsigned DSIZE_DEF    = 8;
    localparam int unsigned PTR_MAXW     = 32;

    // Operands are zero-extended pointers; callers truncate the result to their width.
    function automatic logic [PTR_MAXW-1:0] bin2gray(input logic [PTR_MAXW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAXW-1:0] gray2bin(input logic [PTR_MAXW-1:0] g);
        logic [PTR_MAXW-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < PTR_MAXW; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    // Full when the write Gray pointer equals the read pointer with its top two bits inverted.
    function automatic logic full_match(input logic [PTR_MAXW-1:0] wgray,
                                        input logic [PTR_MAXW-1:0] rgray,
                                        input int unsigned         ptr_w);
        return wgray == (rgray ^ (PTR_MAXW'(3) << (ptr_w - 2)));
    endfunction

endpackage

// File: rtl/fifo_wr_arb_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the last granted requester.
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            enable,
    output logic [NREQ-1:0] gnt
);

    localparam int unsigned LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [LW-1:0] last_q;
    logic [LW-1:0] last_d;
    logic [LW-1:0] idx;
    logic          found;

    // Grant is suppressed while reset is asserted so no write slips through.
    always_comb begin
        gnt    = '0;
        last_d = last_q;
        found  = 1'b0;
        idx    = '0;
        if (rst_n && enable) begin
            for (int unsigned off = 1; off <= NREQ; off++) begin
                idx = LW'((32'(last_q) + off) % NREQ);
                if (!found && req[idx]) begin
                    gnt[idx] = 1'b1;
                    last_d   = idx;
                    found    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= LW'(NREQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/fifo_wr_arb_ctrl.sv
// Write-side FIFO controller: arbitrates NREQ writers, maintains write pointers and full flag.
// Optional registered almost-full output enabled by defining WR_ALMOST_FULL_EN.
module fifo_wr_arb_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDRSIZE     = ADDRSIZE_DEF,
    parameter int unsigned DSIZE        = DSIZE_DEF,
    parameter int unsigned NREQ         = 4,
    parameter int unsigned AFULL_THRESH = (2 ** ADDRSIZE) - 4
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic [ADDRSIZE:0]     wq2_rptr,
    output logic [NREQ-1:0]       gnt,
    output logic                  wclken,
    output logic [ADDRSIZE-1:0]   waddr,
    output logic [DSIZE-1:0]      wdata,
    output logic [ADDRSIZE:0]     wptr,
    output logic                  wfull
`ifdef WR_ALMOST_FULL_EN
   ,output logic                  wafull
`endif
);

    localparam int unsigned PW = ADDRSIZE + 1;

    logic [PW-1:0] wbin_q;
    logic [PW-1:0] wbin_d;
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] wgray_d;
    logic          wfull_q;
    logic          wfull_d;
    logic          winc;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk    (wclk),
        .rst_n  (wrst_n),
        .req    (req),
        .enable (!wfull_q),
        .gnt    (gnt)
    );

    // Data mux: slice of the granted requester, zero when idle.
    always_comb begin
        wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                wdata = req_data[i*DSIZE +: DSIZE];
            end
        end
    end

    assign winc    = |gnt;
    assign wclken  = winc;
    assign waddr   = wbin_q[ADDRSIZE-1:0];
    assign wbin_d  = wbin_q + PW'(winc);
    assign wgray_d = PW'(bin2gray(PTR_MAXW'(wbin_d)));
    assign wfull_d = full_match(PTR_MAXW'(wgray_d), PTR_MAXW'(wq2_rptr), PW);

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin_q  <= '0;
            wptr_q  <= '0;
            wfull_q <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wptr_q  <= wgray_d;
            wfull_q <= wfull_d;
        end
    end

    assign wptr  = wptr_q;
    assign wfull = wfull_q;

`ifdef WR_ALMOST_FULL_EN
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] occ_d;
    logic          wafull_q;
    logic          wafull_d;

    // Occupancy seen from the write side, using the synchronized read pointer.
    assign rbin_s   = PW'(gray2bin(PTR_MAXW'(wq2_rptr)));
    assign occ_d    = wbin_d - rbin_s;
    assign wafull_d = (32'(occ_d) >= 32'(AFULL_THRESH));

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wafull_q <= 1'b0;
        end else begin
            wafull_q <= wafull_d;
        end
    end

    assign wafull = wafull_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Directed bench for fifo_wr_arb_ctrl with an 8-entry FIFO and four requesters.
// Almost-full checks are included when WR_ALMOST_FULL_EN is defined.
module tb_fifo_wr_arb_ctrl;

    localparam int unsigned ADDRSIZE = 3;
    localparam int unsigned DSIZE    = 8;
    localparam int unsigned NREQ     = 4;

    logic                  wclk;
    logic                  wrst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [ADDRSIZE:0]     wq2_rptr;
    logic [NREQ-1:0]       gnt;
    logic                  wclken;
    logic [ADDRSIZE-1:0]   waddr;
    logic [DSIZE-1:0]      wdata;
    logic [ADDRSIZE:0]     wptr;
    logic                  wfull;
`ifdef WR_ALMOST_FULL_EN
    logic                  wafull;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fifo_wr_arb_ctrl #(
        .ADDRSIZE     (ADDRSIZE),
        .DSIZE        (DSIZE),
        .NREQ         (NREQ),
        .AFULL_THRESH (6)
    ) dut (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .req      (req),
        .req_data (req_data),
        .wq2_rptr (wq2_rptr),
        .gnt      (gnt),
        .wclken   (wclken),
        .waddr    (waddr),
        .wdata    (wdata),
        .wptr     (wptr),
        .wfull    (wfull)
`ifdef WR_ALMOST_FULL_EN
       ,.wafull   (wafull)
`endif
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    function automatic logic [3:0] g4(input int unsigned v);
        logic [3:0] b;
        b = 4'(v);
        return b ^ (b >> 1);
    endfunction

    int hist [0:2];

    initial begin
        wrst_n   = 1'b0;
        req      = 4'b1111;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        wq2_rptr = '0;
        #1;
        chk("rst_gnt_async", 32'(gnt), 32'h0);
        chk("rst_wclken_async", 32'(wclken), 32'h0);
        tick(); tick(); tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_wclken", 32'(wclken), 32'h0);
        chk("rst_wptr", 32'(wptr), 32'h0);
        chk("rst_wfull", 32'(wfull), 32'h0);
        chk("rst_waddr", 32'(waddr), 32'h0);
`ifdef WR_ALMOST_FULL_EN
        chk("rst_wafull", 32'(wafull), 32'h0);
`endif

        // Round-robin across all four requesters.
        wrst_n = 1'b1;
        #1;
        chk("rr0_gnt", 32'(gnt), 32'b0001);
        chk("rr0_waddr", 32'(waddr), 32'd0);
        chk("rr0_wdata", 32'(wdata), 32'h11);
        tick();
        chk("rr1_gnt", 32'(gnt), 32'b0010);
        chk("rr1_waddr", 32'(waddr), 32'd1);
        chk("rr1_wdata", 32'(wdata), 32'h22);
        chk("rr1_wptr", 32'(wptr), 32'b0001);
        tick();
        chk("rr2_gnt", 32'(gnt), 32'b0100);
        chk("rr2_waddr", 32'(waddr), 32'd2);
        chk("rr2_wdata", 32'(wdata), 32'h33);
        chk("rr2_wptr", 32'(wptr), 32'b0011);
        tick();
        chk("rr3_gnt", 32'(gnt), 32'b1000);
        chk("rr3_waddr", 32'(waddr), 32'd3);
        chk("rr3_wdata", 32'(wdata), 32'h44);
        chk("rr3_wptr", 32'(wptr), 32'b0010);

        // Reset mid-operation cancels the pending grant and clears state.
        wrst_n = 1'b0;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'h0);
        chk("midrst_wclken", 32'(wclken), 32'h0);
        chk("midrst_wdata", 32'(wdata), 32'h0);
        tick();
        chk("midrst_wptr", 32'(wptr), 32'h0);
        chk("midrst_waddr", 32'(waddr), 32'h0);
        wrst_n = 1'b1;
        #1;
        chk("midrst_rel_gnt", 32'(gnt), 32'b0001);

        // Fill with requester 2 only.
        req = 4'b0100;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fill%0d_gnt", i), 32'(gnt), 32'b0100);
            chk($sformatf("fill%0d_waddr", i), 32'(waddr), 32'(i));
            chk($sformatf("fill%0d_wfull", i), 32'(wfull), 32'h0);
`ifdef WR_ALMOST_FULL_EN
            chk($sformatf("fill%0d_wafull", i), 32'(wafull), (i >= 6) ? 32'h1 : 32'h0);
`endif
            tick();
        end
        chk("full_wfull", 32'(wfull), 32'h1);
        chk("full_wptr", 32'(wptr), 32'b1100);
        chk("full_gnt", 32'(gnt), 32'h0);
        chk("full_wclken", 32'(wclken), 32'h0);
`ifdef WR_ALMOST_FULL_EN
        chk("full_wafull", 32'(wafull), 32'h1);
`endif
        tick();
        chk("full_hold_wptr", 32'(wptr), 32'b1100);
        chk("full_hold_gnt", 32'(gnt), 32'h0);

        // One slot freed by the reader.
        wq2_rptr = 4'b0001;
        #1;
        chk("drain_gnt_before", 32'(gnt), 32'h0);
        tick();
        chk("drain_wfull", 32'(wfull), 32'h0);
        chk("drain_gnt", 32'(gnt), 32'b0100);
        chk("drain_waddr", 32'(waddr), 32'd0);
        tick();
        chk("drain_wptr", 32'(wptr), 32'b1101);
        chk("drain_refull", 32'(wfull), 32'h1);
        chk("drain_gnt_after", 32'(gnt), 32'h0);

        // Reset while full clears the flags.
        wrst_n = 1'b0;
        tick();
        chk("rst2_wfull", 32'(wfull), 32'h0);
        chk("rst2_wptr", 32'(wptr), 32'h0);
`ifdef WR_ALMOST_FULL_EN
        chk("rst2_wafull", 32'(wafull), 32'h0);
`endif
        wrst_n   = 1'b1;
        wq2_rptr = '0;

        // 20 writes with the read pointer trailing two cycles behind.
        req = 4'b0001;
        hist[0] = 0; hist[1] = 0; hist[2] = 0;
        #1;
        for (int n = 0; n < 20; n++) begin
            chk($sformatf("wrap%0d_waddr", n), 32'(waddr), 32'(n % 8));
            chk($sformatf("wrap%0d_gnt", n), 32'(gnt), 32'b0001);
            tick();
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = n + 1;
            wq2_rptr = g4(hist[2]);
            chk($sformatf("wrap%0d_wptr", n), 32'(wptr), 32'(g4(n + 1)));
            chk($sformatf("wrap%0d_wfull", n), 32'(wfull), 32'h0);
            if (n + 1 == 8 || n + 1 == 16) begin
                chk($sformatf("wrap%0d_msb", n), 32'(wptr[ADDRSIZE]), ((n + 1) == 8) ? 32'h1 : 32'h0);
            end
        end
        req = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
